// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler and motion/door sequencer for a single lift car.
// Latches calls, picks the next target floor, drives motor and door commands, and times the door dwell.
module lift_call_scheduler #(
  parameter int FLOORS = 8,
  parameter int FW     = 3,
  parameter int DWELL  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [FLOORS-1:0] i_call,
  input  logic [FW-1:0]     i_floor_pos,
  input  logic              i_at_floor,
  input  logic              i_door_closed,
  input  logic              i_stop,
  output logic              o_motor_up,
  output logic              o_motor_down,
  output logic              o_door_open,
  output logic              o_dir_up,
  output logic [FW-1:0]     o_target,
  output logic [FLOORS-1:0] o_pending,
  output logic              o_busy
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAN  = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_DWELL = 3'd4;
  localparam logic [2:0] S_CLOSE = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [FLOORS-1:0] r_pending;
  logic [FLOORS-1:0] w_pending_next;
  logic [FLOORS-1:0] w_pos_onehot;
  logic [FLOORS-1:0] w_call_mask;
  logic [FLOORS-1:0] w_clr;
  logic [FW-1:0]     r_target;
  logic [FW-1:0]     w_target_next;
  logic              r_dir_up;
  logic              w_dir_next;
  logic [CW-1:0]     r_dwell;
  logic              r_motor_up;
  logic              r_motor_down;
  logic              r_door_open;
  logic              r_busy;
  logic              w_pos_valid;
  logic              w_pos_hit;
  logic              w_call_here;
  logic              w_above_any;
  logic              w_below_any;
  logic [FW-1:0]     w_above_idx;
  logic [FW-1:0]     w_below_idx;

  // A floor index beyond the shaft selects no bit, so it can neither stop the car nor clear a call.
  assign w_pos_valid = (int'(i_floor_pos) < FLOORS);

  always_comb begin
    w_pos_onehot = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (w_pos_valid && (int'(i_floor_pos) == i)) w_pos_onehot[i] = 1'b1;
    end
  end

  assign w_pos_hit   = i_at_floor & (|(r_pending & w_pos_onehot));
  assign w_call_here = |(i_call & w_pos_onehot);

  // Nearest pending floor on each side: lowest one above, highest one below.
  always_comb begin
    w_above_any = 1'b0;
    w_above_idx = '0;
    w_below_any = 1'b0;
    w_below_idx = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(i_floor_pos))) begin
        w_above_any = 1'b1;
        w_above_idx = FW'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (i < int'(i_floor_pos))) begin
        w_below_any = 1'b1;
        w_below_idx = FW'(i);
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_target_next = r_target;
    w_dir_next    = r_dir_up;
    if (i_stop) begin
      w_next = S_HALT;
    end else begin
      case (r_state)
        S_IDLE: if (|r_pending) w_next = S_PLAN;
        S_PLAN: begin
          if (~|r_pending) begin
            w_next = S_IDLE;
          end else if (w_pos_hit) begin
            w_target_next = i_floor_pos;
            w_next        = S_OPEN;
          end else if (i_door_closed) begin
            w_next = S_MOVE;
            if (r_dir_up ? w_above_any : !w_below_any && w_above_any) begin
              w_dir_next    = 1'b1;
              w_target_next = w_above_idx;
            end else if (w_below_any) begin
              w_dir_next    = 1'b0;
              w_target_next = w_below_idx;
            end else begin
              // Only the current floor is pending but the car is not aligned: creep on in the current direction.
              w_target_next = i_floor_pos;
            end
          end
        end
        S_MOVE: begin
          if (w_pos_hit) begin
            w_target_next = i_floor_pos;
            w_next        = S_OPEN;
          end else if (!i_door_closed) begin
            w_next = S_HALT;
          end
        end
        S_OPEN:  w_next = S_DWELL;
        S_DWELL: if (!w_call_here && (r_dwell == '0)) w_next = S_CLOSE;
        S_CLOSE: if (i_door_closed) w_next = S_PLAN;
        S_HALT:  if (i_door_closed) w_next = S_PLAN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // A call for the open floor during dwell only extends the dwell; it is never latched.
  assign w_call_mask    = i_call & ~((r_state == S_DWELL) ? w_pos_onehot : '0);
  assign w_clr          = (r_state == S_OPEN) ? w_pos_onehot : '0;
  assign w_pending_next = (r_pending | w_call_mask) & ~w_clr;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_target     <= '0;
      r_dir_up     <= 1'b1;
      r_dwell      <= '0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_door_open  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_pending    <= w_pending_next;
      r_target     <= w_target_next;
      r_dir_up     <= w_dir_next;
      r_motor_up   <= (w_next == S_MOVE) && w_dir_next;
      r_motor_down <= (w_next == S_MOVE) && !w_dir_next;
      r_door_open  <= (w_next == S_OPEN) || (w_next == S_DWELL);
      r_busy       <= (w_next != S_IDLE);
      if ((r_state == S_OPEN) || ((r_state == S_DWELL) && w_call_here)) begin
        r_dwell <= DWELL_LOAD;
      end else if ((r_state == S_DWELL) && (r_dwell != '0)) begin
        r_dwell <= r_dwell - CW'(1);
      end
    end
  end

  assign o_motor_up   = r_motor_up;
  assign o_motor_down = r_motor_down;
  assign o_door_open  = r_door_open;
  assign o_dir_up     = r_dir_up;
  assign o_target     = r_target;
  assign o_pending    = r_pending;
  assign o_busy       = r_busy;

endmodule
